// File: rtl/vending_pkg.sv
// Shared types and coin-unit constants for the vending output path.
// Owed change is counted in nickel units (5 cents).
package vending_pkg;

    localparam logic [2:0] NICKEL_UNITS     = 3'd1;
    localparam logic [2:0] DIME_UNITS       = 3'd2;
    localparam logic [2:0] DOUBLEDIME_UNITS = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StEjectD,
        StWaitD,
        StEjectN,
        StWaitN,
        StFault
    } payout_state_t;

    // Sum of simultaneous change strobes, in nickel units.
    function automatic logic [2:0] strobe_units(input logic n, input logic d, input logic dd);
        return (n ? NICKEL_UNITS : 3'd0) + (d ? DIME_UNITS : 3'd0)
             + (dd ? DOUBLEDIME_UNITS : 3'd0);
    endfunction

endpackage

// File: rtl/payout_ack_timer.sv
// Hopper acknowledge watchdog: loaded on entry to a wait state, counts down
// while waiting and flags expiry once it has reached zero.
module payout_ack_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic tick,
    input  logic clear,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] count_q;
    logic          active_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (clear) begin
            active_q <= 1'b0;
        end else if (load) begin
            count_q  <= TW'(TIMEOUT);
            active_q <= 1'b1;
        end else if (tick && active_q && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = active_q && (count_q == '0);

endmodule

// File: rtl/coin_payout_dispenser.sv
// Consumer of the vending_machine output strobes: pulses the vend motor and
// pays owed change one coin at a time through a handshaked hopper.
module coin_payout_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned NICKEL_STOCK_INIT = 20,
    parameter int unsigned DIME_STOCK_INIT   = 20,
    parameter int unsigned CNT_W             = 6,
    parameter int unsigned PEND_W            = 8,
    parameter int unsigned ACK_TIMEOUT       = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              deliver,
    input  logic              give_nickel,
    input  logic              give_dime,
    input  logic              give_doubledime,
    input  logic              hopper_ack,
    input  logic              refill_nickel,
    input  logic              refill_dime,
    output logic              vend_motor,
    output logic              eject_nickel,
    output logic              eject_dime,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  nickel_stock,
    output logic [CNT_W-1:0]  dime_stock,
    output logic              fault
);

    // Three spare bits cover the largest strobe sum without wrapping.
    localparam int unsigned AccW = PEND_W + 3;

    payout_state_t     state_q, state_d;
    logic [PEND_W-1:0] pending_d;
    logic [CNT_W-1:0]  nickel_d, dime_d;
    logic              in_wait, ack_dime, ack_nickel, timer_expired;
    logic [2:0]        add_units, sub_units;
    logic [AccW-1:0]   acc;

    assign in_wait    = (state_q == StWaitD) || (state_q == StWaitN);
    assign ack_dime   = hopper_ack && (state_q == StWaitD);
    assign ack_nickel = hopper_ack && (state_q == StWaitN);
    assign add_units  = strobe_units(give_nickel, give_dime, give_doubledime);
    assign sub_units  = ack_dime ? DIME_UNITS : (ack_nickel ? NICKEL_UNITS : 3'd0);
    assign acc        = AccW'(pending) + AccW'(add_units) - AccW'(sub_units);

    payout_ack_timer #(
        .TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clock  (clock),
        .reset  (reset),
        .load   ((state_q == StEjectD) || (state_q == StEjectN)),
        .tick   (in_wait),
        .clear  (ack_dime || ack_nickel || (state_q == StFault)),
        .expired(timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending;
        nickel_d  = nickel_stock;
        dime_d    = dime_stock;

        unique case (state_q)
            StIdle: begin
                if ((pending >= PEND_W'(DIME_UNITS)) && (dime_stock != '0)) begin
                    state_d = StEjectD;
                end else if ((pending >= PEND_W'(NICKEL_UNITS)) && (nickel_stock != '0)) begin
                    state_d = StEjectN;
                end else if (pending != '0) begin
                    state_d = StFault;
                end
            end
            StEjectD: state_d = StWaitD;
            StEjectN: state_d = StWaitN;
            StWaitD, StWaitN: begin
                if (ack_dime || ack_nickel) begin
                    state_d = StIdle;
                end else if (timer_expired) begin
                    state_d = StFault;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase

        // Accumulation is frozen in FAULT; overflow saturates and faults.
        if (state_q != StFault) begin
            if (acc[AccW-1:PEND_W] != '0) begin
                pending_d = '1;
                state_d   = StFault;
            end else begin
                pending_d = acc[PEND_W-1:0];
            end
        end

        if (ack_dime)   dime_d   = dime_stock - 1'b1;
        if (ack_nickel) nickel_d = nickel_stock - 1'b1;
        if (refill_nickel) nickel_d = CNT_W'(NICKEL_STOCK_INIT);
        if (refill_dime)   dime_d   = CNT_W'(DIME_STOCK_INIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            pending      <= '0;
            nickel_stock <= CNT_W'(NICKEL_STOCK_INIT);
            dime_stock   <= CNT_W'(DIME_STOCK_INIT);
            vend_motor   <= 1'b0;
            eject_nickel <= 1'b0;
            eject_dime   <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending      <= pending_d;
            nickel_stock <= nickel_d;
            dime_stock   <= dime_d;
            vend_motor   <= deliver;
            eject_nickel <= (state_d == StEjectN);
            eject_dime   <= (state_d == StEjectD);
            busy         <= (state_d != StIdle) || (pending_d != '0);
            fault        <= (state_d == StFault);
        end
    end

endmodule

// File: tb/tb_coin_payout_dispenser.sv
// Bench for coin_payout_dispenser: three instances with different stock
// settings, each served by an automatic hopper responder.
module tb_coin_payout_dispenser;

    localparam int PW = 8;
    localparam int CW = 6;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] rst_n, deliver, give_n, give_d, give_dd, refill_n, refill_d, hopper_ack;
    logic [2:0] vend, ej_n, ej_d, busy, fault;
    logic [PW-1:0] pending [3];
    logic [CW-1:0] nst [3];
    logic [CW-1:0] dst [3];

    int ack_dly [3];
    logic [2:0] ack_en;
    int checks = 0;
    int errors = 0;
    int n_ej_n [3] = '{0, 0, 0};
    int n_ej_d [3] = '{0, 0, 0};

    coin_payout_dispenser #(.NICKEL_STOCK_INIT(20), .DIME_STOCK_INIT(20)) dut0 (
        .clock(clock), .reset(rst_n[0]), .deliver(deliver[0]), .give_nickel(give_n[0]),
        .give_dime(give_d[0]), .give_doubledime(give_dd[0]), .hopper_ack(hopper_ack[0]),
        .refill_nickel(refill_n[0]), .refill_dime(refill_d[0]), .vend_motor(vend[0]),
        .eject_nickel(ej_n[0]), .eject_dime(ej_d[0]), .busy(busy[0]), .pending(pending[0]),
        .nickel_stock(nst[0]), .dime_stock(dst[0]), .fault(fault[0]));

    coin_payout_dispenser #(.NICKEL_STOCK_INIT(20), .DIME_STOCK_INIT(0)) dut1 (
        .clock(clock), .reset(rst_n[1]), .deliver(deliver[1]), .give_nickel(give_n[1]),
        .give_dime(give_d[1]), .give_doubledime(give_dd[1]), .hopper_ack(hopper_ack[1]),
        .refill_nickel(refill_n[1]), .refill_dime(refill_d[1]), .vend_motor(vend[1]),
        .eject_nickel(ej_n[1]), .eject_dime(ej_d[1]), .busy(busy[1]), .pending(pending[1]),
        .nickel_stock(nst[1]), .dime_stock(dst[1]), .fault(fault[1]));

    coin_payout_dispenser #(.NICKEL_STOCK_INIT(1), .DIME_STOCK_INIT(0)) dut2 (
        .clock(clock), .reset(rst_n[2]), .deliver(deliver[2]), .give_nickel(give_n[2]),
        .give_dime(give_d[2]), .give_doubledime(give_dd[2]), .hopper_ack(hopper_ack[2]),
        .refill_nickel(refill_n[2]), .refill_dime(refill_d[2]), .vend_motor(vend[2]),
        .eject_nickel(ej_n[2]), .eject_dime(ej_d[2]), .busy(busy[2]), .pending(pending[2]),
        .nickel_stock(nst[2]), .dime_stock(dst[2]), .fault(fault[2]));

    // Hopper model: acknowledges each eject ack_dly cycles later, for one cycle.
    for (genvar g = 0; g < 3; g++) begin : g_hop
        logic ack = 1'b0;
        assign hopper_ack[g] = ack;
        initial begin
            forever begin
                @(posedge clock);
                #1;
                if (ack_en[g] && (ej_n[g] || ej_d[g])) begin
                    repeat (ack_dly[g]) @(posedge clock);
                    #1 ack = 1'b1;
                    @(posedge clock);
                    #1 ack = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (ej_n[i]) n_ej_n[i]++;
            if (ej_d[i]) n_ej_d[i]++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int i, input string name);
        int k = 0;
        while (busy[i] && k < 300) begin
            @(negedge clock);
            k++;
        end
        check({name, " busy falls"}, int'(busy[i]), 0);
    endtask

    task automatic wait_eject_dime(input string name);
        int k = 0;
        while (!ej_d[0] && k < 50) begin
            @(negedge clock);
            k++;
        end
        check({name, " eject_dime seen"}, int'(ej_d[0]), 1);
    endtask

    typedef struct {
        logic n, d, dd, refill;
        int   pend, dimes, nickels, dstock, nstock;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int b_d, b_n, k;
        int m_pend, m_nst, m_dst, m_out, m_given, u;
        logic m_vend;

        tbl[0] = '{n: 0, d: 0, dd: 1, refill: 0, pend: 4, dimes: 2, nickels: 0, dstock: 18, nstock: 20};
        tbl[1] = '{n: 1, d: 1, dd: 0, refill: 1, pend: 3, dimes: 1, nickels: 1, dstock: 19, nstock: 19};
        tbl[2] = '{n: 1, d: 0, dd: 0, refill: 0, pend: 1, dimes: 0, nickels: 1, dstock: 19, nstock: 18};
        tbl[3] = '{n: 1, d: 1, dd: 1, refill: 0, pend: 7, dimes: 3, nickels: 1, dstock: 16, nstock: 17};
        tbl[4] = '{n: 0, d: 1, dd: 0, refill: 0, pend: 2, dimes: 1, nickels: 0, dstock: 15, nstock: 17};

        {deliver, give_n, give_d, give_dd, refill_n, refill_d} = '0;
        ack_en = 3'b111;
        ack_dly = '{3, 3, 3};
        rst_n = 3'b111;
        #2 rst_n = 3'b000;
        repeat (2) @(negedge clock);

        check("rst vend", int'(vend[0]), 0);
        check("rst eject_n", int'(ej_n[0]), 0);
        check("rst eject_d", int'(ej_d[0]), 0);
        check("rst busy", int'(busy[0]), 0);
        check("rst fault", int'(fault[0]), 0);
        check("rst pending", int'(pending[0]), 0);
        check("rst nickel_stock", int'(nst[0]), 20);
        check("rst dime_stock", int'(dst[0]), 20);
        check("rst dut1 dime_stock", int'(dst[1]), 0);
        check("rst dut2 nickel_stock", int'(nst[2]), 1);
        rst_n = 3'b111;
        @(negedge clock);

        deliver[0] = 1'b1;
        check("vend before edge", int'(vend[0]), 0);
        @(negedge clock);
        deliver[0] = 1'b0;
        check("vend pulse", int'(vend[0]), 1);
        @(negedge clock);
        check("vend one cycle", int'(vend[0]), 0);

        for (int r = 0; r < 5; r++) begin
            if (tbl[r].refill) begin
                refill_n[0] = 1'b1;
                refill_d[0] = 1'b1;
                @(negedge clock);
                refill_n[0] = 1'b0;
                refill_d[0] = 1'b0;
            end
            b_d = n_ej_d[0];
            b_n = n_ej_n[0];
            give_n[0] = tbl[r].n;
            give_d[0] = tbl[r].d;
            give_dd[0] = tbl[r].dd;
            @(negedge clock);
            {give_n[0], give_d[0], give_dd[0]} = 3'b000;
            check($sformatf("row%0d pending", r), int'(pending[0]), tbl[r].pend);
            wait_idle(0, $sformatf("row%0d", r));
            check($sformatf("row%0d dimes", r), n_ej_d[0] - b_d, tbl[r].dimes);
            check($sformatf("row%0d nickels", r), n_ej_n[0] - b_n, tbl[r].nickels);
            check($sformatf("row%0d pending drained", r), int'(pending[0]), 0);
            check($sformatf("row%0d dime_stock", r), int'(dst[0]), tbl[r].dstock);
            check($sformatf("row%0d nickel_stock", r), int'(nst[0]), tbl[r].nstock);
        end

        // No dimes stocked (dut1) and a single nickel stocked (dut2).
        give_d[1] = 1'b1;
        give_d[2] = 1'b1;
        @(negedge clock);
        give_d[1] = 1'b0;
        give_d[2] = 1'b0;
        check("nodime pending", int'(pending[1]), 2);
        check("onenickel pending", int'(pending[2]), 2);
        wait_idle(1, "nodime");
        check("nodime nickel ejects", n_ej_n[1], 2);
        check("nodime dime ejects", n_ej_d[1], 0);
        check("nodime nickel_stock", int'(nst[1]), 18);
        check("nodime pending drained", int'(pending[1]), 0);
        k = 0;
        while (!fault[2] && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("outofchange fault", int'(fault[2]), 1);
        check("outofchange pending", int'(pending[2]), 1);
        check("outofchange nickel ejects", n_ej_n[2], 1);
        check("outofchange dime ejects", n_ej_d[2], 0);
        refill_n[2] = 1'b1;
        @(negedge clock);
        refill_n[2] = 1'b0;
        check("refill stock in fault", int'(nst[2]), 1);
        check("refill keeps fault", int'(fault[2]), 1);
        rst_n[2] = 1'b0;
        @(negedge clock);
        check("reset clears fault", int'(fault[2]), 0);
        check("reset clears pending", int'(pending[2]), 0);
        rst_n[2] = 1'b1;

        // Ack timeout on dut0.
        ack_en[0] = 1'b0;
        b_d = n_ej_d[0];
        give_d[0] = 1'b1;
        @(negedge clock);
        give_d[0] = 1'b0;
        wait_eject_dime("timeout");
        repeat (16) @(negedge clock);
        check("timeout not yet", int'(fault[0]), 0);
        @(negedge clock);
        check("timeout fault", int'(fault[0]), 1);
        check("timeout pending", int'(pending[0]), 2);
        check("timeout busy", int'(busy[0]), 1);
        check("timeout dime ejects", n_ej_d[0] - b_d, 1);
        give_n[0] = 1'b1;
        deliver[0] = 1'b1;
        @(negedge clock);
        give_n[0] = 1'b0;
        deliver[0] = 1'b0;
        check("fault freezes pending", int'(pending[0]), 2);
        check("fault vend works", int'(vend[0]), 1);
        rst_n[0] = 1'b0;
        @(negedge clock);
        rst_n[0] = 1'b1;
        @(negedge clock);

        // Reset in the middle of a wait.
        b_d = n_ej_d[0];
        give_d[0] = 1'b1;
        @(negedge clock);
        give_d[0] = 1'b0;
        wait_eject_dime("midwait");
        repeat (3) @(negedge clock);
        rst_n[0] = 1'b0;
        #1;
        check("midwait pending", int'(pending[0]), 0);
        check("midwait busy", int'(busy[0]), 0);
        check("midwait dime_stock", int'(dst[0]), 20);
        @(negedge clock);
        rst_n[0] = 1'b1;
        repeat (20) @(negedge clock);
        check("midwait no further eject", n_ej_d[0] - b_d, 1);
        check("midwait stays idle", int'(busy[0]), 0);

        // Randomised traffic against a value-conservation model.
        ack_en[0] = 1'b1;
        m_pend = 0; m_nst = 20; m_dst = 20; m_out = 0; m_given = 0; m_vend = 1'b0;
        for (int c = 0; c < 500; c++) begin
            check("rnd pending", int'(pending[0]), m_pend);
            check("rnd nickel_stock", int'(nst[0]), m_nst);
            check("rnd dime_stock", int'(dst[0]), m_dst);
            check("rnd vend", int'(vend[0]), int'(m_vend));
            check("rnd fault", int'(fault[0]), 0);
            if (ej_d[0]) m_out = 2;
            else if (ej_n[0]) m_out = 1;
            deliver[0] = ($urandom_range(0, 7) == 0);
            give_n[0] = (c < 200) && ($urandom_range(0, 15) == 0);
            give_d[0] = (c < 200) && ($urandom_range(0, 15) == 0);
            give_dd[0] = (c < 200) && ($urandom_range(0, 15) == 0);
            u = int'(give_n[0]) + 2 * int'(give_d[0]) + 4 * int'(give_dd[0]);
            if (m_given + u > 40) begin
                {give_n[0], give_d[0], give_dd[0]} = 3'b000;
                u = 0;
            end
            refill_n[0] = ($urandom_range(0, 40) == 0);
            refill_d[0] = ($urandom_range(0, 40) == 0);
            ack_dly[0] = $urandom_range(1, 6);
            m_given += u;
            m_pend += u;
            if (hopper_ack[0]) begin
                m_pend -= m_out;
                if (m_out == 2) m_dst--;
                else m_nst--;
            end
            if (refill_n[0]) m_nst = 20;
            if (refill_d[0]) m_dst = 20;
            m_vend = deliver[0];
            @(negedge clock);
        end
        {deliver[0], give_n[0], give_d[0], give_dd[0], refill_n[0], refill_d[0]} = '0;
        check("rnd final pending", int'(pending[0]), m_pend);
        check("rnd final drained", m_pend, 0);
        check("rnd final busy", int'(busy[0]), 0);
        check("rnd final dime_stock", int'(dst[0]), m_dst);
        check("rnd final nickel_stock", int'(nst[0]), m_nst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
